lsu_dmem_port: RTL and testbench

- Load/store unit sitting in MEM stage of the pipelined RV32I core.
- Consumes the memory-side decode fields (mem read/write select, funct3 load/store select, ALU address, rs2 data) and executes the access on the data-memory request/grant/rvalid bus.
- Returns an aligned, sign/zero-extended load result or store completion, and stalls the pipeline while the access is outstanding.

---
 rtl/lsu_pkg.sv | 55 +++++
 rtl/lsu_load_align.sv | 37 +++
 rtl/lsu_dmem_port.sv | 153 +++++++++++++++
 tb/tb_lsu_dmem_port.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// FSM state type and the byte-enable / store-lane / legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Byte enables from access size (funct3[1:0]) and the low address bits.
    function automatic logic [3:0] lsu_byte_en(input logic [1:0] size,
                                               input logic [1:0] a);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << {a[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store operand across every lane it may land in.
    function automatic logic [31:0] lsu_store_data(input logic [1:0]  size,
                                                   input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Misaligned halfword/word or an encoding that is not a valid load/store.
    function automatic logic lsu_illegal(input logic       rw,
                                         input logic [2:0] f3,
                                         input logic [1:0] a);
        logic bad_f3;
        logic bad_al;
        if (rw) bad_f3 = (f3 > F3_W);
        else    bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        bad_al = ((f3[1:0] == 2'b01) && a[0]) ||
                 ((f3[1:0] == 2'b10) && (a != 2'b00));
        return bad_f3 || bad_al;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of the returned memory word and
// sign- or zero-extends it according to the load funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane selection by the low address bits.
    always_comb begin
        case (addr_i)
            2'd0:    byte_lane = rdata_i[7:0];
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            default: byte_lane = rdata_i[31:24];
        endcase
        half_lane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extension by load type; word loads pass through untouched.
    always_comb begin
        case (funct3_i)
            F3_B:    data_o = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    data_o = {{16{half_lane[15]}}, half_lane};
            F3_BU:   data_o = {24'h0, byte_lane};
            F3_HU:   data_o = {16'h0, half_lane};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_port.sv
// MEM-stage load/store unit. Captures one access from the pipeline, runs it
// on the req/gnt/rvalid data-memory bus and returns a one-cycle response
// while holding the pipeline stalled for the duration of the access.
module lsu_dmem_port
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              mem_rw_i,
    input  logic [2:0]        ld_st_sel_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic              rsp_valid_o,
    output logic [31:0]       rdata_o,
    output logic              misaligned_o,
    output logic              bus_err_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rw_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              dmem_req_q;
    logic              rsp_valid_q;
    logic [31:0]       rdata_q;
    logic              misaligned_q;
    logic              bus_err_q;
    logic [31:0]       ld_data;
    logic              timeout_hit;

    lsu_load_align u_align (
        .rdata_i  (dmem_rdata_i),
        .addr_i   (addr_q[1:0]),
        .funct3_i (f3_q),
        .data_o   (ld_data)
    );

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    // Access FSM; every bus and response output is a register written here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rw_q         <= 1'b0;
            f3_q         <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= 4'b0000;
            dmem_req_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rdata_q      <= '0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        rw_q    <= mem_rw_i;
                        f3_q    <= ld_st_sel_i;
                        addr_q  <= addr_i;
                        wdata_q <= lsu_store_data(ld_st_sel_i[1:0], wdata_i);
                        be_q    <= lsu_byte_en(ld_st_sel_i[1:0], addr_i[1:0]);
                        if (lsu_illegal(mem_rw_i, ld_st_sel_i, addr_i[1:0])) begin
                            // Illegal accesses never touch the bus.
                            state_q      <= RESP;
                            rsp_valid_q  <= 1'b1;
                            misaligned_q <= 1'b1;
                            rdata_q      <= '0;
                        end else begin
                            state_q    <= REQ;
                            dmem_req_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_q <= 1'b0;
                        if (rw_q) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rdata_q     <= '0;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rdata_q     <= ld_data;
                    end else if (timeout_hit) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        bus_err_q   <= 1'b1;
                        rdata_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    // RESP: single-cycle pulse, then clear the response fields.
                    state_q      <= IDLE;
                    rsp_valid_q  <= 1'b0;
                    rdata_q      <= '0;
                    misaligned_q <= 1'b0;
                    bus_err_q    <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline handshake; stall covers the accept cycle so the issuing
    // instruction stays in MEM until its response is produced.
    assign req_ready_o  = (state_q == IDLE);
    assign stall_o      = ((state_q == IDLE) && req_valid_i) ||
                          (state_q == REQ) || (state_q == WAIT);

    assign rsp_valid_o  = rsp_valid_q;
    assign rdata_o      = rdata_q;
    assign misaligned_o = misaligned_q;
    assign bus_err_o    = bus_err_q;

    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = rw_q;
    assign dmem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Bench for lsu_dmem_port: scoreboarded loads/stores against a small
// memory-side responder with programmable grant and rvalid delays.
module tb_lsu_dmem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        mem_rw;
    logic [2:0]  ld_st_sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        misaligned;
    logic        bus_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    lsu_dmem_port #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .mem_rw_i      (mem_rw),
        .ld_st_sel_i   (ld_st_sel),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .stall_o       (stall),
        .rsp_valid_o   (rsp_valid),
        .rdata_o       (rdata),
        .misaligned_o  (misaligned),
        .bus_err_o     (bus_err),
        .dmem_req_o    (dmem_req),
        .dmem_we_o     (dmem_we),
        .dmem_addr_o   (dmem_addr),
        .dmem_be_o     (dmem_be),
        .dmem_wdata_o  (dmem_wdata),
        .dmem_gnt_i    (dmem_gnt),
        .dmem_rvalid_i (dmem_rvalid),
        .dmem_rdata_i  (dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access; entered just after a negedge with the DUT idle, returns
    // just after the negedge following the response (DUT idle again).
    // gd: cycles dmem_req is held before grant; rvd: extra WAIT cycles
    // before rvalid, negative means rvalid never comes.
    task automatic run(input logic rw, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int gd, input int rvd,
                       input logic [31:0] mem, input logic [31:0] exp_rd,
                       input logic mis, input logic err,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd);
        exp_t e;
        exp_t got;
        int   lat_exp;
        int   reqc;
        int   stallc;
        int   g;
        bit   done;
        e.rd = exp_rd; e.mis = mis; e.err = err;
        sb.push_back(e);
        if (mis)          lat_exp = 1;
        else if (rw)      lat_exp = gd + 2;
        else if (rvd < 0) lat_exp = gd + 2 + 16;
        else              lat_exp = gd + 3 + rvd;
        chk("ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; mem_rw = rw; ld_st_sel = f3; addr = a; wdata = wd;
        #1;
        stallc = stall ? 1 : 0;
        reqc = 0; g = -1; done = 1'b0;
        for (int c = 1; c < 80 && !done; c++) begin
            @(negedge clk);
            req_valid   = 1'b0;
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = 32'h5A5A_5A5A;
            if (rsp_valid) begin
                done = 1'b1;
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    chk("rdata", rdata, got.rd);
                    chk("misaligned", {31'b0, misaligned}, {31'b0, got.mis});
                    chk("bus_err", {31'b0, bus_err}, {31'b0, got.err});
                end
                chk("latency", c, lat_exp);
                chk("req_cycles", reqc, mis ? 0 : gd + 1);
                chk("stall_cycles", stallc, lat_exp);
                chk("stall_in_resp", {31'b0, stall}, 32'd0);
            end else begin
                if (stall) stallc++;
                if (dmem_req) begin
                    chk("be", {28'b0, dmem_be}, {28'b0, exp_be});
                    chk("addr", dmem_addr, a & 32'hFFFF_FFFC);
                    chk("we", {31'b0, dmem_we}, {31'b0, rw});
                    if (rw) chk("wdata", dmem_wdata, exp_wd);
                    if (reqc == gd) begin
                        dmem_gnt = 1'b1;
                        g = c;
                    end
                    reqc++;
                end
                if (g >= 0 && !rw && rvd >= 0 && c == g + 1 + rvd) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = mem;
                end
            end
        end
        if (!done) chk("rsp_never_came", 32'd0, 32'd1);
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        chk("rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);
        chk("ready_after", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; mem_rw = 1'b0; ld_st_sel = 3'b000;
        addr = '0; wdata = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_be", {28'b0, dmem_be}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        //   rw    f3      addr          wdata         gd rvd mem           exp_rd        mis   err   be       exp_wd
        run(1'b0, 3'b010, 32'h0000_0100, 32'h0,         0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 4'b1111, 32'h0);
        run(1'b0, 3'b000, 32'h0000_0103, 32'h0,         0, 0, 32'h80123456, 32'hFFFFFF80, 1'b0, 1'b0, 4'b1000, 32'h0);
        run(1'b0, 3'b100, 32'h0000_0103, 32'h0,         0, 0, 32'h80123456, 32'h00000080, 1'b0, 1'b0, 4'b1000, 32'h0);
        run(1'b0, 3'b001, 32'h0000_0102, 32'h0,         0, 0, 32'h80123456, 32'hFFFF8012, 1'b0, 1'b0, 4'b1100, 32'h0);
        run(1'b0, 3'b101, 32'h0000_0100, 32'h0,         0, 0, 32'h80128765, 32'h00008765, 1'b0, 1'b0, 4'b0011, 32'h0);
        run(1'b0, 3'b000, 32'h0000_0101, 32'h0,         0, 0, 32'h80128765, 32'hFFFFFF87, 1'b0, 1'b0, 4'b0010, 32'h0);
        run(1'b0, 3'b010, 32'h0000_0104, 32'h0,         1, 2, 32'h13572468, 32'h13572468, 1'b0, 1'b0, 4'b1111, 32'h0);
        // stores
        run(1'b1, 3'b000, 32'h0000_0201, 32'h000000A5,  3, 0, 32'h0,        32'h0,        1'b0, 1'b0, 4'b0010, 32'hA5A5A5A5);
        run(1'b1, 3'b001, 32'h0000_0202, 32'h1234BEEF,  0, 0, 32'h0,        32'h0,        1'b0, 1'b0, 4'b1100, 32'hBEEFBEEF);
        run(1'b1, 3'b010, 32'h0000_0204, 32'h12345678,  1, 0, 32'h0,        32'h0,        1'b0, 1'b0, 4'b1111, 32'h12345678);
        // illegal accesses: no bus traffic, response next cycle
        run(1'b0, 3'b010, 32'h0000_0102, 32'h0,         0, 0, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0);
        run(1'b1, 3'b001, 32'h0000_0301, 32'hFFFF,      0, 0, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0);
        run(1'b0, 3'b011, 32'h0000_0100, 32'h0,         0, 0, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0);
        run(1'b1, 3'b100, 32'h0000_0100, 32'h0,         0, 0, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0);
        // timeout, then late rvalid ignored, then a normal back-to-back load
        run(1'b0, 3'b010, 32'h0000_0108, 32'h0,         0, -1, 32'h0,       32'h0,        1'b0, 1'b1, 4'b1111, 32'h0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("late_rvalid_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("late_rvalid_ready", {31'b0, req_ready}, 32'd1);
        run(1'b0, 3'b010, 32'h0000_010C, 32'h0,         0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0, 4'b1111, 32'h0);

        // reset while the request is held in REQ: dmem_req drops at once
        req_valid = 1'b1; mem_rw = 1'b0; ld_st_sel = 3'b010; addr = 32'h110;
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_before_rst", {31'b0, dmem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_req_drop", {31'b0, dmem_req}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset during WAIT, then stray rvalid after release
        req_valid = 1'b1; mem_rw = 1'b0; ld_st_sel = 3'b010; addr = 32'h114;
        @(negedge clk);
        req_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        @(negedge clk);
        chk("wait_stall", {31'b0, stall}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_wait_stall", {31'b0, stall}, 32'd0);
        chk("rst_wait_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_wait_rsp", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_8888;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("stray_rvalid_rsp", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("stray_rvalid_rsp2", {31'b0, rsp_valid}, 32'd0);
        chk("stray_rvalid_ready", {31'b0, req_ready}, 32'd1);
        chk("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
